qpu_exu_oitf_mc: RTL and testbench

- Second-generation outstanding-instruction tracker for the QPU EXU. It records in-flight classical long-pipe instructions and in-flight measurements.
- Classical entries retire out of order, addressed by itag, instead of retiring in FIFO order.
- The measurement qubit-list FIFO has explicit full/empty tracking.
- Per-qubit saturating-free counters replace single qubit flags, so several measurements of one qubit can be outstanding at once.
- Sits between dispatch (hazard checks, itag issue) and the long-pipe write-back and MCU result-return paths.

---
 rtl/qpu_exu_oitf_mc.sv | 162 ++++++++++++++++
 tb/tb_qpu_exu_oitf_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_oitf_mc.sv
// Outstanding-instruction tracker: out-of-order retiring classical entries plus a
// measurement qubit-list FIFO with per-qubit outstanding counters.
module qpu_exu_oitf_mc #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ITAG_W    = 2,
  parameter int unsigned RFIDX_W   = 5,
  parameter int unsigned QUBIT_NUM = 12,
  parameter int unsigned MDEPTH    = 4,
  parameter int unsigned MPTR_W    = 2,
  parameter int unsigned QCNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dis_cl_ena,
  output logic                 dis_cf_ready,
  output logic [ITAG_W-1:0]    dis_itag,
  input  logic                 disp_i_rs1en,
  input  logic                 disp_i_rs2en,
  input  logic                 disp_i_rdwen,
  input  logic [RFIDX_W-1:0]   disp_i_rs1idx,
  input  logic [RFIDX_W-1:0]   disp_i_rs2idx,
  input  logic [RFIDX_W-1:0]   disp_i_rdidx,
  input  logic                 ret_cl_ena,
  input  logic [ITAG_W-1:0]    ret_itag,
  output logic [RFIDX_W-1:0]   ret_rdidx,
  output logic                 ret_rdwen,
  output logic                 ret_cl_err,
  output logic                 oitfrd_match_disprs1,
  output logic                 oitfrd_match_disprs2,
  output logic                 oitfrd_match_disprd,
  output logic                 oitf_empty,
  output logic [ITAG_W:0]      oitf_cnt,
  input  logic                 dis_qf_ena,
  output logic                 dis_mf_ready,
  input  logic [QUBIT_NUM-1:0] disp_i_ql,
  input  logic                 disp_i_qfren,
  input  logic                 ret_qf_ena,
  output logic [QUBIT_NUM-1:0] ret_mf,
  output logic                 moitf_empty,
  output logic                 oitfqf_match_dispql
);

  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [RFIDX_W-1:0] rdidx_q [DEPTH];
  logic [DEPTH-1:0]   rdwen_q;
  logic               alloc_en, ret_vld, ret_ok, found;

  // Classical table: allocation, indexed retire read-out, hazards and occupancy.
  always_comb begin
    dis_itag             = '0;
    found                = 1'b0;
    ret_vld              = 1'b0;
    ret_rdidx            = '0;
    ret_rdwen            = 1'b0;
    oitf_cnt             = '0;
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!vld_q[i] && !found) begin
        dis_itag = ITAG_W'(i);
        found    = 1'b1;
      end
      if (ret_itag == ITAG_W'(i) && vld_q[i]) begin
        ret_vld   = 1'b1;
        ret_rdidx = rdidx_q[i];
        ret_rdwen = rdwen_q[i];
      end
      oitf_cnt = oitf_cnt + {{ITAG_W{1'b0}}, vld_q[i]};
      if (vld_q[i] && rdwen_q[i]) begin
        if (disp_i_rs1en && rdidx_q[i] == disp_i_rs1idx) oitfrd_match_disprs1 = 1'b1;
        if (disp_i_rs2en && rdidx_q[i] == disp_i_rs2idx) oitfrd_match_disprs2 = 1'b1;
        if (disp_i_rdwen && rdidx_q[i] == disp_i_rdidx)  oitfrd_match_disprd  = 1'b1;
      end
    end
    dis_cf_ready = ~(&vld_q);
    oitf_empty   = ~(|vld_q);
    ret_cl_err   = ret_cl_ena & ~ret_vld;
    alloc_en     = dis_cl_ena & dis_cf_ready;
    ret_ok       = ret_cl_ena & ret_vld;
    vld_d        = vld_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_en && dis_itag == ITAG_W'(i)) vld_d[i] = 1'b1;
      if (ret_ok && ret_itag == ITAG_W'(i))   vld_d[i] = 1'b0;
    end
  end

  logic [MPTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 wflag_q, wflag_d, rflag_q, rflag_d;
  logic [QUBIT_NUM-1:0] mem_q [MDEPTH];
  logic [QCNT_W-1:0]    qcnt_q [QUBIT_NUM];
  logic [QCNT_W-1:0]    qcnt_d [QUBIT_NUM];
  logic                 mf_full, push, pop;
  logic [QUBIT_NUM-1:0] qbusy;

  always_comb begin
    mf_full      = (wptr_q == rptr_q) && (wflag_q != rflag_q);
    moitf_empty  = (wptr_q == rptr_q) && (wflag_q == rflag_q);
    dis_mf_ready = ~mf_full;
    ret_mf       = moitf_empty ? '0 : mem_q[rptr_q];
    push         = dis_qf_ena & ~mf_full;
    pop          = ret_qf_ena & ~moitf_empty;
    wptr_d       = wptr_q;
    wflag_d      = wflag_q;
    rptr_d       = rptr_q;
    rflag_d      = rflag_q;
    // Pointers wrap explicitly so non-power-of-two depths work.
    if (push) begin
      if (wptr_q == MPTR_W'(MDEPTH - 1)) begin
        wptr_d  = '0;
        wflag_d = ~wflag_q;
      end else begin
        wptr_d = wptr_q + MPTR_W'(1);
      end
    end
    if (pop) begin
      if (rptr_q == MPTR_W'(MDEPTH - 1)) begin
        rptr_d  = '0;
        rflag_d = ~rflag_q;
      end else begin
        rptr_d = rptr_q + MPTR_W'(1);
      end
    end
    for (int unsigned j = 0; j < QUBIT_NUM; j++) begin
      qcnt_d[j] = qcnt_q[j];
      if (push && disp_i_ql[j] && !(pop && ret_mf[j]))      qcnt_d[j] = qcnt_q[j] + QCNT_W'(1);
      else if (pop && ret_mf[j] && !(push && disp_i_ql[j])) qcnt_d[j] = qcnt_q[j] - QCNT_W'(1);
      qbusy[j] = (qcnt_q[j] != '0);
    end
    oitfqf_match_dispql = disp_i_qfren & (|(qbusy & disp_i_ql));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      wflag_q <= 1'b0;
      rflag_q <= 1'b0;
      for (int unsigned j = 0; j < QUBIT_NUM; j++) qcnt_q[j] <= '0;
    end else begin
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wflag_q <= wflag_d;
      rflag_q <= rflag_d;
      for (int unsigned j = 0; j < QUBIT_NUM; j++) qcnt_q[j] <= qcnt_d[j];
    end
  end

  // Payload storage carries no reset; validity is tracked by vld_q and the pointers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst_n && alloc_en && dis_itag == ITAG_W'(i)) begin
        rdidx_q[i] <= disp_i_rdidx;
        rdwen_q[i] <= disp_i_rdwen;
      end
    end
    if (rst_n && push) mem_q[wptr_q] <= disp_i_ql;
  end

endmodule

// File: tb/tb_qpu_exu_oitf_mc.sv
// Directed self-checking bench for qpu_exu_oitf_mc with hand-computed expectations.
module tb_qpu_exu_oitf_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dis_cl_ena, dis_cf_ready;
  logic [1:0]  dis_itag;
  logic        disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
  logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic        ret_cl_ena;
  logic [1:0]  ret_itag;
  logic [4:0]  ret_rdidx;
  logic        ret_rdwen, ret_cl_err;
  logic        oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd;
  logic        oitf_empty;
  logic [2:0]  oitf_cnt;
  logic        dis_qf_ena, dis_mf_ready;
  logic [11:0] disp_i_ql;
  logic        disp_i_qfren, ret_qf_ena;
  logic [11:0] ret_mf;
  logic        moitf_empty, oitfqf_match_dispql;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qpu_exu_oitf_mc dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dis_cl_ena           (dis_cl_ena),
    .dis_cf_ready         (dis_cf_ready),
    .dis_itag             (dis_itag),
    .disp_i_rs1en         (disp_i_rs1en),
    .disp_i_rs2en         (disp_i_rs2en),
    .disp_i_rdwen         (disp_i_rdwen),
    .disp_i_rs1idx        (disp_i_rs1idx),
    .disp_i_rs2idx        (disp_i_rs2idx),
    .disp_i_rdidx         (disp_i_rdidx),
    .ret_cl_ena           (ret_cl_ena),
    .ret_itag             (ret_itag),
    .ret_rdidx            (ret_rdidx),
    .ret_rdwen            (ret_rdwen),
    .ret_cl_err           (ret_cl_err),
    .oitfrd_match_disprs1 (oitfrd_match_disprs1),
    .oitfrd_match_disprs2 (oitfrd_match_disprs2),
    .oitfrd_match_disprd  (oitfrd_match_disprd),
    .oitf_empty           (oitf_empty),
    .oitf_cnt             (oitf_cnt),
    .dis_qf_ena           (dis_qf_ena),
    .dis_mf_ready         (dis_mf_ready),
    .disp_i_ql            (disp_i_ql),
    .disp_i_qfren         (disp_i_qfren),
    .ret_qf_ena           (ret_qf_ena),
    .ret_mf               (ret_mf),
    .moitf_empty          (moitf_empty),
    .oitfqf_match_dispql  (oitfqf_match_dispql)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow after a further 1ns.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_cf_ready"}, 32'(dis_cf_ready), 32'd1);
    check({pfx, "_itag"}, 32'(dis_itag), 32'd0);
    check({pfx, "_oitf_empty"}, 32'(oitf_empty), 32'd1);
    check({pfx, "_oitf_cnt"}, 32'(oitf_cnt), 32'd0);
    check({pfx, "_mf_ready"}, 32'(dis_mf_ready), 32'd1);
    check({pfx, "_moitf_empty"}, 32'(moitf_empty), 32'd1);
    check({pfx, "_ret_mf"}, 32'(ret_mf), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    dis_cl_ena = 0; disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rdwen = 0;
    disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rdidx = 0;
    ret_cl_ena = 0; ret_itag = 0; dis_qf_ena = 0; disp_i_ql = 0;
    disp_i_qfren = 0; ret_qf_ena = 0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check_reset_state("rst");
    check("rst_rs1", 32'(oitfrd_match_disprs1), 32'd0);
    check("rst_ret_rdidx", 32'(ret_rdidx), 32'd0);
    check("rst_ret_rdwen", 32'(ret_rdwen), 32'd0);
    check("rst_ret_err", 32'(ret_cl_err), 32'd0);
    check("rst_qmatch", 32'(oitfqf_match_dispql), 32'd0);

    // Fill the classical table with rdidx 1..4.
    cyc();
    for (int k = 0; k < 4; k++) begin
      dis_cl_ena = 1; disp_i_rdidx = 5'(k + 1); disp_i_rdwen = 1;
      #1;
      check($sformatf("alloc_itag%0d", k), 32'(dis_itag), 32'(k));
      check($sformatf("alloc_ready%0d", k), 32'(dis_cf_ready), 32'd1);
      cyc();
    end
    disp_i_rdidx = 5'd9;
    #1;
    check("full_ready", 32'(dis_cf_ready), 32'd0);
    check("full_cnt", 32'(oitf_cnt), 32'd4);
    check("full_itag", 32'(dis_itag), 32'd0);
    cyc();
    dis_cl_ena = 0; ret_itag = 2'd0;
    #1;
    check("full_nochg_cnt", 32'(oitf_cnt), 32'd4);
    check("full_nochg_rd0", 32'(ret_rdidx), 32'd1);

    // Out-of-order retire of itag 2, then a repeat retire of it.
    ret_cl_ena = 1; ret_itag = 2'd2;
    #1;
    check("ret2_rdidx", 32'(ret_rdidx), 32'd3);
    check("ret2_rdwen", 32'(ret_rdwen), 32'd1);
    check("ret2_err", 32'(ret_cl_err), 32'd0);
    cyc();
    ret_cl_ena = 0;
    #1;
    check("ret2_itag", 32'(dis_itag), 32'd2);
    check("ret2_cnt", 32'(oitf_cnt), 32'd3);
    ret_cl_ena = 1;
    #1;
    check("reret_err", 32'(ret_cl_err), 32'd1);
    check("reret_rdidx", 32'(ret_rdidx), 32'd0);
    cyc();
    ret_cl_ena = 1; ret_itag = 2'd1;
    #1;
    check("reret_cnt", 32'(oitf_cnt), 32'd3);
    check("ret1_rdidx", 32'(ret_rdidx), 32'd2);
    cyc();

    // vld = 1001: allocate (gets itag 1, rdidx 5) while retiring itag 0.
    dis_cl_ena = 1; disp_i_rdidx = 5'd5; disp_i_rdwen = 1;
    ret_cl_ena = 1; ret_itag = 2'd0;
    #1;
    check("sim_itag", 32'(dis_itag), 32'd1);
    check("sim_cnt_before", 32'(oitf_cnt), 32'd2);
    cyc();
    dis_cl_ena = 0; ret_cl_ena = 0; disp_i_rdwen = 0;
    #1;
    check("sim_cnt_after", 32'(oitf_cnt), 32'd2);
    check("sim_itag_after", 32'(dis_itag), 32'd0);

    // Hazards against vld = 1010 (itag1 rd5, itag3 rd4).
    disp_i_rs1en = 1; disp_i_rs1idx = 5'd5;
    disp_i_rs2en = 1; disp_i_rs2idx = 5'd4;
    disp_i_rdwen = 1; disp_i_rdidx = 5'd1;
    #1;
    check("haz_rs1", 32'(oitfrd_match_disprs1), 32'd1);
    check("haz_rs2", 32'(oitfrd_match_disprs2), 32'd1);
    check("haz_rd_retired", 32'(oitfrd_match_disprd), 32'd0);
    disp_i_rs1en = 0; disp_i_rs2idx = 5'd3;
    #1;
    check("haz_rs1_off", 32'(oitfrd_match_disprs1), 32'd0);
    check("haz_rs2_retired", 32'(oitfrd_match_disprs2), 32'd0);
    disp_i_rs2en = 0; disp_i_rdwen = 0;

    // Measurement FIFO and qubit counters.
    cyc();
    dis_qf_ena = 1; disp_i_ql = 12'h001;
    #1;
    check("mf_push1_ret", 32'(ret_mf), 32'h000);
    cyc();
    disp_i_ql = 12'h003;
    #1;
    check("mf_push1_vis", 32'(ret_mf), 32'h001);
    check("mf_nonempty", 32'(moitf_empty), 32'd0);
    cyc();
    dis_qf_ena = 0; disp_i_qfren = 1; disp_i_ql = 12'h001;
    #1;
    check("q_match_q0", 32'(oitfqf_match_dispql), 32'd1);
    disp_i_ql = 12'h004;
    #1;
    check("q_match_q2", 32'(oitfqf_match_dispql), 32'd0);
    disp_i_qfren = 0; ret_qf_ena = 1;
    #1;
    check("pop1_mf", 32'(ret_mf), 32'h001);
    cyc();
    disp_i_qfren = 1; disp_i_ql = 12'h001;
    #1;
    check("pop2_mf", 32'(ret_mf), 32'h003);
    check("q0_still_busy", 32'(oitfqf_match_dispql), 32'd1);
    cyc();
    ret_qf_ena = 0; disp_i_ql = 12'hfff;
    #1;
    check("q_all_clear", 32'(oitfqf_match_dispql), 32'd0);
    check("mf_empty", 32'(moitf_empty), 32'd1);
    check("mf_empty_ret", 32'(ret_mf), 32'h000);
    disp_i_qfren = 0;

    // Fill to full, then push+pop while full.
    for (int k = 0; k < 4; k++) begin
      dis_qf_ena = 1; disp_i_ql = 12'(12'h010 << k);
      cyc();
    end
    #1;
    check("mf_full_ready", 32'(dis_mf_ready), 32'd0);
    check("mf_full_head", 32'(ret_mf), 32'h010);
    disp_i_ql = 12'h100; ret_qf_ena = 1;
    cyc();
    dis_qf_ena = 0;
    #1;
    check("fullpp_ready", 32'(dis_mf_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      #1;
      check($sformatf("drain_mf%0d", k), 32'(ret_mf), 32'(12'h010 << k));
      cyc();
    end
    disp_i_qfren = 1; disp_i_ql = 12'h100;
    #1;
    check("fullpp_push_dropped", 32'(oitfqf_match_dispql), 32'd0);
    check("drained_empty", 32'(moitf_empty), 32'd1);
    disp_i_qfren = 0;
    cyc();
    #1;
    check("pop_empty_empty", 32'(moitf_empty), 32'd1);
    check("pop_empty_ready", 32'(dis_mf_ready), 32'd1);
    ret_qf_ena = 0;

    // Mid-traffic reset with enables asserted.
    dis_cl_ena = 1; dis_qf_ena = 1; disp_i_ql = 12'h002;
    cyc();
    #1;
    check("pre_rst_cnt", 32'(oitf_cnt), 32'd3);
    check("pre_rst_mf", 32'(ret_mf), 32'h002);
    rst_n = 0; disp_i_ql = 12'hfff;
    cyc();
    rst_n = 1; dis_cl_ena = 0; dis_qf_ena = 0; disp_i_qfren = 1;
    #1;
    check_reset_state("mid");
    check("mid_qmatch", 32'(oitfqf_match_dispql), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
